sram_burst_master: RTL and testbench

- Initiator side of the team's dual-port SRAM port protocol: active-low chip select and write enable, 10-bit address, 24-bit data, one-cycle registered read latency.
- Converts a burst request (start address, length, direction) into a sequence of single-word SRAM cycles on one SRAM port.
- Writes take data from a valid/ready stream. Reads return data on a valid/ready stream through a small FIFO, so the consumer can apply backpressure.
- Sits between PPU pipeline stages (line fetch / line store) and one port of the SRAM.

---
 rtl/sram_burst_master_if.sv | 61 ++++++
 rtl/sram_burst_master.sv | 166 ++++++++++++++++
 tb/tb_sram_burst_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_burst_master_if
// Purpose  : Bundle of the burst-request, write-stream, read-stream and SRAM
//            port signals used by sram_burst_master.
//            The master modport is the block's own view.
//            The slave modport is the view of the client and SRAM around it.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_burst_master_if #(
    parameter int AW = 10,
    parameter int DW = 24,
    parameter int LW = 8
);
    // Burst request
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WR;
    logic [AW-1:0] REQ_ADDR;
    logic [LW-1:0] REQ_LEN;
    // Write-data stream
    logic          WR_VALID;
    logic          WR_READY;
    logic [DW-1:0] WR_DATA;
    // Read-data stream
    logic          RD_VALID;
    logic          RD_READY;
    logic [DW-1:0] RD_DATA;
    // Burst completion pulse
    logic          DONE;
    // SRAM port
    logic          SRAM_CS_N;
    logic          SRAM_WE_N;
    logic [AW-1:0] SRAM_ADDR;
    logic [DW-1:0] SRAM_WDATA;
    logic [DW-1:0] SRAM_RDATA;

    modport master (
        input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_LEN,
        input  WR_VALID, WR_DATA,
        input  RD_READY,
        input  SRAM_RDATA,
        output REQ_READY, WR_READY,
        output RD_VALID, RD_DATA,
        output DONE,
        output SRAM_CS_N, SRAM_WE_N, SRAM_ADDR, SRAM_WDATA
    );

    modport slave (
        output REQ_VALID, REQ_WR, REQ_ADDR, REQ_LEN,
        output WR_VALID, WR_DATA,
        output RD_READY,
        output SRAM_RDATA,
        input  REQ_READY, WR_READY,
        input  RD_VALID, RD_DATA,
        input  DONE,
        input  SRAM_CS_N, SRAM_WE_N, SRAM_ADDR, SRAM_WDATA
    );
endinterface
`default_nettype wire

// File: rtl/sram_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_burst_master
// Purpose  : Turns a burst request into single-word SRAM cycles on one port.
//            Write data comes from a valid/ready stream.
//            Read data returns through a small FIFO so the consumer can stall.
// Revision : 1.0 - initial release
// ============================================================================
module sram_burst_master #(
    parameter int AW            = 10,
    parameter int DW            = 24,
    parameter int LW            = 8,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                sram_clk,
    input  logic                sram_rst,
    sram_burst_master_if.master bus
);

    localparam int PW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(RD_FIFO_DEPTH + 1);
    localparam logic [CW:0]   c_fifo_depth = (CW+1)'(RD_FIFO_DEPTH);
    localparam logic [PW-1:0] c_last_ptr   = PW'(RD_FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [LW:0]   r_remaining;
    logic [1:0]    r_inflight;   // read commands issued but not yet pushed
    logic          r_rd_s2;      // SRAM_RDATA carries a requested word this cycle
    logic          r_cs_n;
    logic          r_we_n;
    logic          r_done;
    logic [AW-1:0] r_sram_addr;
    logic [DW-1:0] r_sram_wdata;

    logic [DW-1:0] r_fifo_mem [RD_FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_wr_accept;
    logic w_credit;
    logic w_rd_issue;
    logic w_push;
    logic w_pop;
    logic w_last_push;

    // Credits cover both words already buffered and words still in the SRAM pipe,
    // so a push can never find the FIFO full.
    assign w_credit    = ((CW+1)'(r_count) + (CW+1)'(r_inflight)) < c_fifo_depth;
    assign w_wr_accept = (r_state == S_WRITE) && (r_remaining != '0) && bus.WR_VALID;
    assign w_rd_issue  = (r_state == S_READ) && (r_remaining != '0) && w_credit;
    assign w_push      = r_rd_s2;
    assign w_pop       = bus.RD_READY && (r_count != '0);
    assign w_last_push = (r_state == S_READ) && w_push &&
                         (r_remaining == '0) && (r_inflight == 2'd1);

    assign bus.REQ_READY  = (r_state == S_IDLE);
    assign bus.WR_READY   = (r_state == S_WRITE) && (r_remaining != '0);
    assign bus.RD_VALID   = (r_count != '0);
    assign bus.RD_DATA    = r_fifo_mem[r_rd_ptr];
    assign bus.DONE       = r_done;
    assign bus.SRAM_CS_N  = r_cs_n;
    assign bus.SRAM_WE_N  = r_we_n;
    assign bus.SRAM_ADDR  = r_sram_addr;
    assign bus.SRAM_WDATA = r_sram_wdata;

    // Burst FSM: sequences the request, drives registered SRAM pins, tracks reads in flight
    always_ff @(posedge sram_clk or posedge sram_rst) begin
        if (sram_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_inflight   <= '0;
            r_rd_s2      <= 1'b0;
            r_cs_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_done       <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_done  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_we_n  <= 1'b1;
            // A read command on the pins this cycle returns data next cycle
            r_rd_s2 <= !r_cs_n && r_we_n;

            case ({w_rd_issue, w_push})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (bus.REQ_VALID) begin
                        r_addr      <= bus.REQ_ADDR;
                        r_remaining <= {1'b0, bus.REQ_LEN} + 1'b1;
                        r_state     <= bus.REQ_WR ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_wr_accept) begin
                        r_cs_n       <= 1'b0;
                        r_we_n       <= 1'b0;
                        r_sram_addr  <= r_addr;
                        r_sram_wdata <= bus.WR_DATA;
                        r_addr       <= r_addr + 1'b1;
                        r_remaining  <= r_remaining - 1'b1;
                    end else if (r_remaining == '0) begin
                        // Last beat's pin cycle has just ended
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_rd_issue) begin
                        r_cs_n      <= 1'b0;
                        r_sram_addr <= r_addr;
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                    if (w_last_push) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-return FIFO: captures SRAM_RDATA one cycle after each read command
    always_ff @(posedge sram_clk or posedge sram_rst) begin
        if (sram_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= bus.SRAM_RDATA;
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_burst_master
// Purpose  : Directed self-checking bench for sram_burst_master with a
//            behavioural single-port SRAM attached to its pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_burst_master;

    localparam int AW    = 10;
    localparam int DW    = 24;
    localparam int LW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_burst_master_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

    sram_burst_master #(.AW(AW), .DW(DW), .LW(LW), .RD_FIFO_DEPTH(DEPTH)) dut (
        .sram_clk (clk),
        .sram_rst (rst),
        .bus      (bus)
    );

    // Behavioural SRAM: unwritten words read back as 0xC00000 | address
    bit   [DW-1:0] wmem   [1<<AW];
    bit            wvalid [1<<AW];
    logic [DW-1:0] rdata_q = '0;
    assign bus.SRAM_RDATA = rdata_q;

    always @(posedge clk) begin
        if (bus.SRAM_CS_N === 1'b0) begin
            if (bus.SRAM_WE_N === 1'b0) begin
                wmem[bus.SRAM_ADDR]   <= bus.SRAM_WDATA;
                wvalid[bus.SRAM_ADDR] <= 1'b1;
            end else begin
                rdata_q <= wvalid[bus.SRAM_ADDR] ? wmem[bus.SRAM_ADDR]
                                                 : (24'hC00000 | DW'(bus.SRAM_ADDR));
            end
        end
    end

    // Pin and stream monitor, sampled mid-cycle
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [AW-1:0] rd_addr_q [$];
    logic [DW-1:0] pop_q     [$];
    int            n_done = 0;

    always @(negedge clk) begin
        if (bus.SRAM_CS_N === 1'b0) begin
            if (bus.SRAM_WE_N === 1'b0) begin
                wr_addr_q.push_back(bus.SRAM_ADDR);
                wr_data_q.push_back(bus.SRAM_WDATA);
            end else begin
                rd_addr_q.push_back(bus.SRAM_ADDR);
            end
        end
        if (bus.DONE === 1'b1) n_done++;
        if (bus.RD_VALID === 1'b1 && bus.RD_READY === 1'b1) pop_q.push_back(bus.RD_DATA);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        pop_q.delete();
        n_done = 0;
    endtask

    task automatic request(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = wr;
        bus.REQ_ADDR  = addr;
        bus.REQ_LEN   = len;
        step();
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus.SRAM_CS_N !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b, expected 1", bus.SRAM_CS_N); end
        n_cmp++; if (bus.SRAM_WE_N !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b, expected 1", bus.SRAM_WE_N); end
        n_cmp++; if (bus.SRAM_ADDR !== 10'h000) begin n_fail++; $display("FAIL reset_addr: got %h, expected 000", bus.SRAM_ADDR); end
        n_cmp++; if (bus.SRAM_WDATA !== 24'h0) begin n_fail++; $display("FAIL reset_wdata: got %h, expected 0", bus.SRAM_WDATA); end
        n_cmp++; if (bus.REQ_READY !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 1", bus.REQ_READY); end
        n_cmp++; if (bus.WR_READY !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b, expected 0", bus.WR_READY); end
        n_cmp++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, expected 0", bus.RD_VALID); end
        n_cmp++; if (bus.RD_DATA !== 24'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h, expected 0", bus.RD_DATA); end
        n_cmp++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", bus.DONE); end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_write();
        logic [AW-1:0] exp_a [4];
        logic [DW-1:0] exp_d;
        exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        clear_mon();
        request(1'b1, 10'h3FE, 8'd3);
        n_cmp++; if (bus.REQ_READY !== 1'b0) begin n_fail++; $display("FAIL wr_req_ready_busy: got %b, expected 0", bus.REQ_READY); end
        n_cmp++; if (bus.WR_READY !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b, expected 1", bus.WR_READY); end
        bus.WR_VALID = 1'b1;
        bus.WR_DATA  = 24'hA00001;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_d = 24'hA00001 + DW'(i);
            n_cmp++; if (bus.SRAM_CS_N !== 1'b0 || bus.SRAM_WE_N !== 1'b0) begin n_fail++; $display("FAIL wr_pins beat %0d: got cs_n=%b we_n=%b, expected 0/0", i, bus.SRAM_CS_N, bus.SRAM_WE_N); end
            n_cmp++; if (bus.SRAM_ADDR !== exp_a[i]) begin n_fail++; $display("FAIL wr_addr beat %0d: got %h, expected %h", i, bus.SRAM_ADDR, exp_a[i]); end
            n_cmp++; if (bus.SRAM_WDATA !== exp_d) begin n_fail++; $display("FAIL wr_data beat %0d: got %h, expected %h", i, bus.SRAM_WDATA, exp_d); end
            bus.WR_DATA = exp_d + 24'h1;
            if (i == 3) bus.WR_VALID = 1'b0;
        end
        step();
        n_cmp++; if (bus.SRAM_CS_N !== 1'b1) begin n_fail++; $display("FAIL wr_end_cs_n: got %b, expected 1", bus.SRAM_CS_N); end
        n_cmp++; if (bus.DONE !== 1'b1) begin n_fail++; $display("FAIL wr_done: got %b, expected 1", bus.DONE); end
        n_cmp++; if (bus.REQ_READY !== 1'b1) begin n_fail++; $display("FAIL wr_idle_ready: got %b, expected 1", bus.REQ_READY); end
        step();
        n_cmp++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL wr_done_width: got %b, expected 0", bus.DONE); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL wr_done_count: got %0d, expected 1", n_done); end
        n_cmp++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL wr_cycle_count: got %0d, expected 4", wr_addr_q.size()); end
    endtask

    task automatic test_readback();
        logic [DW-1:0] exp_d;
        clear_mon();
        bus.RD_READY = 1'b1;
        request(1'b0, 10'h3FE, 8'd3);
        n_cmp++; if (bus.SRAM_CS_N !== 1'b1) begin n_fail++; $display("FAIL rd_t0_cs_n: got %b, expected 1", bus.SRAM_CS_N); end
        step();
        n_cmp++; if (bus.SRAM_CS_N !== 1'b0 || bus.SRAM_WE_N !== 1'b1 || bus.SRAM_ADDR !== 10'h3FE) begin n_fail++; $display("FAIL rd_t1_cmd: got cs_n=%b we_n=%b addr=%h, expected 0/1/3fe", bus.SRAM_CS_N, bus.SRAM_WE_N, bus.SRAM_ADDR); end
        n_cmp++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL rd_t1_valid: got %b, expected 0", bus.RD_VALID); end
        step();
        n_cmp++; if (bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL rd_t2_valid: got %b, expected 0", bus.RD_VALID); end
        for (int i = 0; i < 4; i++) begin
            step();
            exp_d = 24'hA00001 + DW'(i);
            n_cmp++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== exp_d) begin n_fail++; $display("FAIL rd_word %0d: got valid=%b data=%h, expected 1/%h", i, bus.RD_VALID, bus.RD_DATA, exp_d); end
            n_cmp++; if (bus.DONE !== (i == 3)) begin n_fail++; $display("FAIL rd_done word %0d: got %b, expected %b", i, bus.DONE, (i == 3)); end
        end
        step();
        n_cmp++; if (bus.RD_VALID !== 1'b0 || bus.DONE !== 1'b0) begin n_fail++; $display("FAIL rd_after: got valid=%b done=%b, expected 0/0", bus.RD_VALID, bus.DONE); end
        n_cmp++; if (n_done != 1 || rd_addr_q.size() != 4) begin n_fail++; $display("FAIL rd_totals: got done=%0d cmds=%0d, expected 1/4", n_done, rd_addr_q.size()); end
    endtask

    task automatic test_write_gaps();
        logic [6:0]    pat;
        logic [DW-1:0] exp_d;
        int            k;
        pat = 7'b1011001;
        k   = 0;
        clear_mon();
        request(1'b1, 10'h200, 8'd3);
        for (int j = 0; j < 7; j++) begin
            bus.WR_VALID = pat[j];
            bus.WR_DATA  = 24'hD00000 + DW'(k);
            step();
            n_cmp++; if (bus.SRAM_CS_N !== !pat[j]) begin n_fail++; $display("FAIL gap_cs_n cycle %0d: got %b, expected %b", j, bus.SRAM_CS_N, !pat[j]); end
            if (pat[j]) begin
                n_cmp++; if (bus.SRAM_ADDR !== 10'h200 + AW'(k)) begin n_fail++; $display("FAIL gap_addr beat %0d: got %h, expected %h", k, bus.SRAM_ADDR, 10'h200 + AW'(k)); end
                k++;
            end
        end
        bus.WR_VALID = 1'b0;
        step();
        n_cmp++; if (bus.DONE !== 1'b1 || bus.SRAM_CS_N !== 1'b1) begin n_fail++; $display("FAIL gap_done: got done=%b cs_n=%b, expected 1/1", bus.DONE, bus.SRAM_CS_N); end
        step();
        n_cmp++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL gap_write_count: got %0d, expected 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            exp_d = 24'hD00000 + DW'(i);
            n_cmp++; if (wr_addr_q[i] !== 10'h200 + AW'(i) || wr_data_q[i] !== exp_d) begin n_fail++; $display("FAIL gap_write %0d: got %h/%h, expected %h/%h", i, wr_addr_q[i], wr_data_q[i], 10'h200 + AW'(i), exp_d); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_d;
        int            budget;
        clear_mon();
        bus.RD_READY = 1'b0;
        request(1'b0, 10'h010, 8'd7);
        repeat (10) step();
        n_cmp++; if (rd_addr_q.size() != 4) begin n_fail++; $display("FAIL bp_cmds_stalled: got %0d, expected 4", rd_addr_q.size()); end
        n_cmp++; if (bus.SRAM_CS_N !== 1'b1) begin n_fail++; $display("FAIL bp_cs_n_idle: got %b, expected 1", bus.SRAM_CS_N); end
        n_cmp++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 24'hC00010) begin n_fail++; $display("FAIL bp_head: got valid=%b data=%h, expected 1/c00010", bus.RD_VALID, bus.RD_DATA); end
        bus.RD_READY = 1'b1;
        budget = 0;
        while (!(n_done == 1 && bus.RD_VALID === 1'b0) && budget < 40) begin
            step();
            budget++;
        end
        n_cmp++; if (budget >= 40) begin n_fail++; $display("FAIL bp_drain_timeout: got %0d cycles, expected < 40", budget); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d, expected 1", n_done); end
        n_cmp++; if (pop_q.size() != 8 || rd_addr_q.size() != 8) begin n_fail++; $display("FAIL bp_totals: got pops=%0d cmds=%0d, expected 8/8", pop_q.size(), rd_addr_q.size()); end
        for (int i = 0; i < 8 && i < pop_q.size() && i < rd_addr_q.size(); i++) begin
            exp_d = 24'hC00010 + DW'(i);
            n_cmp++; if (pop_q[i] !== exp_d || rd_addr_q[i] !== 10'h010 + AW'(i)) begin n_fail++; $display("FAIL bp_word %0d: got data=%h addr=%h, expected %h/%h", i, pop_q[i], rd_addr_q[i], exp_d, 10'h010 + AW'(i)); end
        end
    endtask

    task automatic test_abort();
        int n_cmd_at_rst;
        clear_mon();
        bus.RD_READY = 1'b1;
        request(1'b0, 10'h020, 8'd7);
        repeat (5) step();
        #1 rst = 1'b1;
        n_cmd_at_rst = rd_addr_q.size();
        #1;
        n_cmp++; if (bus.SRAM_CS_N !== 1'b1 || bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: got cs_n=%b rd_valid=%b, expected 1/0", bus.SRAM_CS_N, bus.RD_VALID); end
        n_cmp++; if (bus.REQ_READY !== 1'b1 || bus.DONE !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: got req_ready=%b done=%b, expected 1/0", bus.REQ_READY, bus.DONE); end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) step();
        n_cmp++; if (rd_addr_q.size() != n_cmd_at_rst || bus.RD_VALID !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: got cmds=%0d valid=%b, expected %0d/0", rd_addr_q.size(), bus.RD_VALID, n_cmd_at_rst); end
        clear_mon();
        request(1'b0, 10'h021, 8'd0);
        step();
        n_cmp++; if (bus.SRAM_CS_N !== 1'b0 || bus.SRAM_ADDR !== 10'h021) begin n_fail++; $display("FAIL post_abort_cmd: got cs_n=%b addr=%h, expected 0/021", bus.SRAM_CS_N, bus.SRAM_ADDR); end
        step();
        step();
        n_cmp++; if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 24'hC00021 || bus.DONE !== 1'b1) begin n_fail++; $display("FAIL post_abort_word: got valid=%b data=%h done=%b, expected 1/c00021/1", bus.RD_VALID, bus.RD_DATA, bus.DONE); end
        step();
        n_cmp++; if (bus.RD_VALID !== 1'b0 || rd_addr_q.size() != 1) begin n_fail++; $display("FAIL post_abort_end: got valid=%b cmds=%0d, expected 0/1", bus.RD_VALID, rd_addr_q.size()); end
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_WR    = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_LEN   = '0;
        bus.WR_VALID  = 1'b0;
        bus.WR_DATA   = '0;
        bus.RD_READY  = 1'b0;
        test_reset();
        test_write();
        test_readback();
        test_write_gaps();
        test_backpressure();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
